vga_draw_arbiter: RTL and testbench

//  Shares the single VGA adapter plot port between the screen-drawing engines
//  (start/end screens, tower drawer, car animator, HUD).

---
 rtl/vga_draw_arbiter_pkg.sv | 22 ++
 rtl/vga_draw_arbiter_rr_pick.sv | 50 +++++
 rtl/vga_draw_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_arbiter_pkg.sv
// Shared constants and state encoding for the VGA plot-port arbiter and the draw engines.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Screen geometry is 160x120 with 3-bit colour. The draw engines use the
// same IDLE/BUSY encoding, so their status can be compared directly with
// the arbiter's.
package vga_draw_arbiter_pkg;

   localparam int SCREEN_X_W = 8;
   localparam int SCREEN_Y_W = 7;
   localparam int COLOUR_W   = 3;

   // Requester index width; NUM_REQ is at most 8.
   localparam int ID_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// Round-robin pick: chooses the first requester strictly after 'last', wrapping.
// Latency: combinational.
// Backpressure: none; pick_vld is low when no request is pending.
//
// Ports:
//   req      in   NUM_REQ  pending requests
//   last     in   ID_W     index of the most recent holder
//   pick     out  NUM_REQ  one-hot winner (all-zero when req == 0)
//   pick_id  out  ID_W     index of the winner
//   pick_vld out  1        at least one request is pending
module rr_pick
   import vga_draw_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] pick,
   output logic [ID_W-1:0]    pick_id,
   output logic               pick_vld
);

   logic [NUM_REQ-1:0] hi_mask;
   logic [NUM_REQ-1:0] upper;
   logic [NUM_REQ-1:0] cand;

   always_comb begin
      hi_mask = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         hi_mask[k] = (ID_W'(k) > last);
      end
      // Requests above 'last' take priority; if there are none, wrap to
      // the lowest request overall.
      upper = req & hi_mask;
      cand  = (|upper) ? upper : req;

      // Isolate the lowest set bit of cand.
      pick = cand & (~cand + NUM_REQ'(1));

      pick_id = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (cand[k]) begin
            pick_id = ID_W'(k);
         end
      end
   end

   assign pick_vld = |req;

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the single VGA plot port between draw engines; round-robin grant, held until release.
// Latency: grant 1 cycle after request (plus one bubble after each release); pixel path registered, 1 cycle.
// Backpressure: none on pixels; a holder that neither plots nor releases for TIMEOUT cycles is revoked.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   req/release_in/plot_in      per-requester request level, finish pulse, pixel valid
//   x_in/y_in/colour_in         packed per-requester pixel, requester k at [k*W +: W]
//   grant, busy                 one-hot grant and "grant held"
//   timeout_err, timeout_id     revoke pulse and sticky index of last revoked requester
//   vga_x/vga_y/vga_colour/vga_plot  registered pixel stream to the adapter
module vga_draw_arbiter
   import vga_draw_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int X_W     = SCREEN_X_W,
   parameter int Y_W     = SCREEN_Y_W,
   parameter int C_W     = COLOUR_W,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 65535
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     release_in,
   input  logic [NUM_REQ-1:0]     plot_in,
   input  logic [NUM_REQ*X_W-1:0] x_in,
   input  logic [NUM_REQ*Y_W-1:0] y_in,
   input  logic [NUM_REQ*C_W-1:0] colour_in,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [ID_W-1:0]        timeout_id,
   output logic [X_W-1:0]         vga_x,
   output logic [Y_W-1:0]         vga_y,
   output logic [C_W-1:0]         vga_colour,
   output logic                   vga_plot
);

   state_t             state, state_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [ID_W-1:0]    hold_id, hold_nxt;
   logic [ID_W-1:0]    last, last_nxt;
   logic [TO_W-1:0]    wdog, wdog_nxt;
   logic               terr_nxt;
   logic [ID_W-1:0]    tid_nxt;

   logic [NUM_REQ-1:0] pick;
   logic [ID_W-1:0]    pick_id;
   logic               pick_vld;

   // Holder's view of its own inputs. Masking with grant makes every
   // non-holder invisible; in IDLE grant is zero so all of these are zero.
   logic               h_plot, h_rel, h_req;
   logic [X_W-1:0]     hx;
   logic [Y_W-1:0]     hy;
   logic [C_W-1:0]     hc;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req      (req),
      .last     (last),
      .pick     (pick),
      .pick_id  (pick_id),
      .pick_vld (pick_vld)
   );

   assign h_plot = |(plot_in & grant);
   assign h_rel  = |(release_in & grant);
   assign h_req  = |(req & grant);

   always_comb begin
      hx = '0;
      hy = '0;
      hc = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            hx = x_in[k*X_W +: X_W];
            hy = y_in[k*Y_W +: Y_W];
            hc = colour_in[k*C_W +: C_W];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      hold_nxt  = hold_id;
      last_nxt  = last;
      wdog_nxt  = wdog;
      terr_nxt  = 1'b0;
      tid_nxt   = timeout_id;

      unique case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = BUSY;
               grant_nxt = pick;
               hold_nxt  = pick_id;
               wdog_nxt  = '0;
            end
         end
         BUSY: begin
            if (h_rel || !h_req) begin
               // A release wins over a watchdog expiry in the same cycle.
               state_nxt = IDLE;
               grant_nxt = '0;
               last_nxt  = hold_id;
            end else if (wdog == TO_W'(TIMEOUT - 1) && !h_plot) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               last_nxt  = hold_id;
               terr_nxt  = 1'b1;
               tid_nxt   = hold_id;
            end else if (h_plot) begin
               wdog_nxt = '0;
            end else if (wdog != '1) begin
               wdog_nxt = wdog + TO_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         grant       <= '0;
         hold_id     <= '0;
         last        <= ID_W'(NUM_REQ - 1);
         wdog        <= '0;
         timeout_err <= 1'b0;
         timeout_id  <= '0;
         vga_plot    <= 1'b0;
         vga_x       <= '0;
         vga_y       <= '0;
         vga_colour  <= '0;
      end else begin
         state       <= state_nxt;
         grant       <= grant_nxt;
         hold_id     <= hold_nxt;
         last        <= last_nxt;
         wdog        <= wdog_nxt;
         timeout_err <= terr_nxt;
         timeout_id  <= tid_nxt;
         // A plot in the releasing cycle still goes out: h_plot uses the
         // grant held during that cycle.
         vga_plot    <= h_plot;
         if (h_plot) begin
            vga_x      <= hx;
            vga_y      <= hy;
            vga_colour <= hc;
         end
      end
   end

   assign busy = (state == BUSY);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter: vector table plus directed multi-cycle sequences.
module tb_vga_draw_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  req, release_in, plot_in;
   logic [31:0] x_in;
   logic [27:0] y_in;
   logic [11:0] colour_in;
   logic [3:0]  grant;
   logic        busy, timeout_err, vga_plot;
   logic [2:0]  timeout_id;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;

   vga_draw_arbiter #(
      .NUM_REQ (4),
      .X_W     (8),
      .Y_W     (7),
      .C_W     (3),
      .TO_W    (16),
      .TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req         (req),
      .release_in  (release_in),
      .plot_in     (plot_in),
      .x_in        (x_in),
      .y_in        (y_in),
      .colour_in   (colour_in),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err),
      .timeout_id  (timeout_id),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] lx [4];
   logic [6:0] ly [4];
   logic [2:0] lc [4];

   typedef struct {
      logic       rstn;
      logic [3:0] req;
      logic [3:0] rel;
      logic [3:0] plot;
      logic [3:0] g;
      logic       b;
      logic       vp;
      logic [7:0] vx;
      logic [6:0] vy;
      logic [2:0] vc;
      logic       te;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(input logic rstn, input logic [3:0] rq, input logic [3:0] rl,
                               input logic [3:0] pl, input logic [3:0] g, input logic b,
                               input logic vp, input logic [7:0] vx, input logic [6:0] vy,
                               input logic [2:0] vc, input logic te);
      vec_t v;
      v.rstn = rstn; v.req = rq; v.rel = rl; v.plot = pl;
      v.g = g; v.b = b; v.vp = vp; v.vx = vx; v.vy = vy; v.vc = vc; v.te = te;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] rl, input logic [3:0] pl);
      resetn     = r;
      req        = rq;
      release_in = rl;
      plot_in    = pl;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic b, input logic vp,
                          input logic [7:0] vx, input logic [6:0] vy, input logic [2:0] vc,
                          input logic te, input logic [2:0] tid);
      chk({tag, " grant"},       32'(grant),       32'(g));
      chk({tag, " busy"},        32'(busy),        32'(b));
      chk({tag, " vga_plot"},    32'(vga_plot),    32'(vp));
      chk({tag, " vga_x"},       32'(vga_x),       32'(vx));
      chk({tag, " vga_y"},       32'(vga_y),       32'(vy));
      chk({tag, " vga_colour"},  32'(vga_colour),  32'(vc));
      chk({tag, " timeout_err"}, 32'(timeout_err), 32'(te));
      chk({tag, " timeout_id"},  32'(timeout_id),  32'(tid));
   endtask

   initial begin
      #50000;
      $display("FAIL sim_time_limit: got expired want finished");
      $fatal(1);
   end

   initial begin
      lx[0] = 8'd10;  ly[0] = 7'd20;  lc[0] = 3'd1;
      lx[1] = 8'd159; ly[1] = 7'd119; lc[1] = 3'd7;
      lx[2] = 8'd50;  ly[2] = 7'd60;  lc[2] = 3'd2;
      lx[3] = 8'd70;  ly[3] = 7'd80;  lc[3] = 3'd5;
      x_in      = {lx[3], lx[2], lx[1], lx[0]};
      y_in      = {ly[3], ly[2], ly[1], ly[0]};
      colour_in = {lc[3], lc[2], lc[1], lc[0]};

      // rstn req rel plot | grant busy vplot vx vy vc terr
      tbl[0]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0,   0,   0, 0, 0);
      tbl[1]  = mk(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 0, 0,   0,   0, 0, 0);
      tbl[2]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 1, 0,   0,   0, 0, 0);
      tbl[3]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 1, 0,   0,   0, 0, 0);
      tbl[4]  = mk(1, 4'b0101, 4'b0000, 4'b0101, 4'b0001, 1, 1,  10,  20, 1, 0);
      tbl[5]  = mk(1, 4'b0101, 4'b0100, 4'b0000, 4'b0001, 1, 0,  10,  20, 1, 0);
      tbl[6]  = mk(1, 4'b0101, 4'b0001, 4'b0000, 4'b0000, 0, 0,  10,  20, 1, 0);
      tbl[7]  = mk(1, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 1, 0,  10,  20, 1, 0);
      tbl[8]  = mk(1, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 0, 0,  10,  20, 1, 0);
      tbl[9]  = mk(1, 4'b0110, 4'b0000, 4'b0000, 4'b0010, 1, 0,  10,  20, 1, 0);
      tbl[10] = mk(1, 4'b0110, 4'b0000, 4'b0110, 4'b0010, 1, 1, 159, 119, 7, 0);
      tbl[11] = mk(1, 4'b0110, 4'b0000, 4'b0100, 4'b0010, 1, 0, 159, 119, 7, 0);
      tbl[12] = mk(1, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 0, 1, 159, 119, 7, 0);
      tbl[13] = mk(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 0, 159, 119, 7, 0);
      tbl[14] = mk(1, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1, 1,  50,  60, 2, 0);
      tbl[15] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0,  50,  60, 2, 0);
      tbl[16] = mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0,  50,  60, 2, 0);

      drive(0, 4'b0000, 4'b0000, 4'b0000);
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].rstn, tbl[i].req, tbl[i].rel, tbl[i].plot);
         tick();
         chk_out($sformatf("row%0d", i), tbl[i].g, tbl[i].b, tbl[i].vp, tbl[i].vx,
                 tbl[i].vy, tbl[i].vc, tbl[i].te, 3'd0);
      end

      // Fairness: all four request, each holder plots 3 times then releases.
      drive(0, 4'b1111, 4'b0000, 4'b0000);
      tick();
      chk_out("fair_reset", 4'b0000, 0, 0, 0, 0, 0, 0, 3'd0);
      drive(1, 4'b1111, 4'b0000, 4'b0000);
      tick();
      for (int n = 0; n < 5; n++) begin
         int h;
         h = n % 4;
         chk($sformatf("fair%0d grant", n), 32'(grant), 32'(1) << h);
         chk($sformatf("fair%0d busy", n), 32'(busy), 32'd1);
         for (int p = 0; p < 3; p++) begin
            drive(1, 4'b1111, 4'b0000, 4'b1111);
            tick();
            chk($sformatf("fair%0d plot", n), 32'(vga_plot), 32'd1);
            chk($sformatf("fair%0d x", n), 32'(vga_x), 32'(lx[h]));
            chk($sformatf("fair%0d colour", n), 32'(vga_colour), 32'(lc[h]));
         end
         drive(1, 4'b1111, 4'(32'(1) << h), 4'b0000);
         tick();
         chk($sformatf("fair%0d bubble", n), 32'(grant), 32'd0);
         chk($sformatf("fair%0d bubble_busy", n), 32'(busy), 32'd0);
         chk($sformatf("fair%0d bubble_plot", n), 32'(vga_plot), 32'd0);
         drive(1, (n == 4) ? 4'b1100 : 4'b1111, 4'b0000, 4'b0000);
         tick();
      end

      // Watchdog: holder 2 plots once midway, then stalls for 8 cycles.
      chk("to grant2", 32'(grant), 32'b0100);
      for (int i = 0; i < 5; i++) begin
         drive(1, 4'b1100, 4'b0000, 4'b0000);
         tick();
         chk($sformatf("to pre%0d grant", i), 32'(grant), 32'b0100);
      end
      drive(1, 4'b1100, 4'b0000, 4'b0100);
      tick();
      chk("to midplot", 32'(vga_plot), 32'd1);
      for (int i = 0; i < 7; i++) begin
         drive(1, 4'b1100, 4'b0000, 4'b0000);
         tick();
         chk($sformatf("to idle%0d grant", i), 32'(grant), 32'b0100);
         chk($sformatf("to idle%0d err", i), 32'(timeout_err), 32'd0);
      end
      drive(1, 4'b1100, 4'b0000, 4'b0000);
      tick();
      chk("to revoke grant", 32'(grant), 32'd0);
      chk("to revoke busy", 32'(busy), 32'd0);
      chk("to revoke err", 32'(timeout_err), 32'd1);
      chk("to revoke id", 32'(timeout_id), 32'd2);
      tick();
      chk("to after err", 32'(timeout_err), 32'd0);
      chk("to after id", 32'(timeout_id), 32'd2);
      chk("to next grant", 32'(grant), 32'b1000);

      // Release coinciding with watchdog expiry counts as a release.
      for (int i = 0; i < 7; i++) begin
         drive(1, 4'b1100, 4'b0000, 4'b0000);
         tick();
         chk($sformatf("tr idle%0d grant", i), 32'(grant), 32'b1000);
      end
      drive(1, 4'b1100, 4'b1000, 4'b0000);
      tick();
      chk("tr grant", 32'(grant), 32'd0);
      chk("tr err", 32'(timeout_err), 32'd0);
      chk("tr id", 32'(timeout_id), 32'd2);
      drive(1, 4'b1100, 4'b0000, 4'b0000);
      tick();
      chk("tr regrant", 32'(grant), 32'b0100);

      // Reset while the holder is plotting.
      drive(1, 4'b1100, 4'b0000, 4'b0100);
      tick();
      chk("rst pre plot", 32'(vga_plot), 32'd1);
      chk("rst pre x", 32'(vga_x), 32'd50);
      drive(0, 4'b1100, 4'b0000, 4'b0100);
      tick();
      chk_out("rst mid", 4'b0000, 0, 0, 0, 0, 0, 0, 3'd0);
      drive(1, 4'b1111, 4'b0000, 4'b0000);
      tick();
      chk("rst first grant", 32'(grant), 32'b0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
